// File: rtl/shared_pkg.sv
// Shared types for the parametrised SPI slave: FSM state encoding and RAM command codes.
package shared_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_miso_serializer.sv
// MISO serializer: loads one RAM word and shifts it out MSB first, one bit per clock.
module spi_miso_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] data,
    output logic              MISO,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] sr;
    logic [CNT_W-1:0]  cnt;

    // done marks the cycle in which the final bit is on the line.
    assign done = busy && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            sr   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            MISO <= 1'b0;
        end else if (clear) begin
            sr   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            MISO <= 1'b0;
        end else if (load) begin
            MISO <= data[DATA_W-1];
            sr   <= {data[DATA_W-2:0], 1'b0};
            cnt  <= CNT_W'(DATA_W - 1);
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == '0) begin
                MISO <= 1'b0;
                busy <= 1'b0;
            end else begin
                MISO <= sr[DATA_W-1];
                sr   <= {sr[DATA_W-2:0], 1'b0};
                cnt  <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end: deserialises {cmd, payload} frames to the RAM and
// serialises RAM read data back on MISO, with frame-abort and optional tx-wait timeout reporting.
module spi_slave_param
    import shared_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TX_WAIT_MAX = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid,
    output logic               MISO,
    output logic [DATA_W+1:0]  rx_data,
    output logic               rx_valid,
    output logic               frame_err,
    output spi_state_e         cs
);

    localparam int RX_W   = DATA_W + 2;
    localparam int CNT_W  = $clog2(RX_W + 1);
    localparam int WAIT_W = (TX_WAIT_MAX > 1) ? $clog2(TX_WAIT_MAX) : 1;

    localparam logic [CNT_W-1:0]  RX_LAST   = CNT_W'(RX_W - 1);
    localparam logic [CNT_W-1:0]  RX_FULL   = CNT_W'(RX_W);
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TX_WAIT_MAX > 0) ? WAIT_W'(TX_WAIT_MAX - 1) : '0;

    spi_state_e        ns;
    logic [RX_W-2:0]   sr;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              rd_addr_seen;
    logic              captured;
    logic              tx_done;
    logic              timed_out;
    logic              ser_busy;
    logic              ser_done;

    logic receiving, abort, rx_done, waiting, load, incomplete;

    assign receiving  = (cs == WRITE) || (cs == READ_ADD) || (cs == READ_DATA);
    assign abort      = (cs != IDLE) && SS_n;
    assign rx_done    = (bit_cnt == RX_FULL);
    assign waiting    = (cs == READ_DATA) && rx_done && !captured && !timed_out && !SS_n && !ser_busy;
    assign load       = waiting && tx_valid;
    assign incomplete = !rx_done || ((cs == READ_DATA) && !tx_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cs <= IDLE;
        else        cs <= ns;
    end

    always_comb begin
        // NOTE: next state defaults to the current state first, so no path can infer a latch.
        ns = cs;
        case (cs)
            IDLE:    if (!SS_n) ns = CHK_CMD;
            CHK_CMD: begin
                if (SS_n)              ns = IDLE;
                else if (!MOSI)        ns = WRITE;
                else if (rd_addr_seen) ns = READ_DATA;
                else                   ns = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: if (SS_n) ns = IDLE;
            default: ns = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr           <= '0;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            rd_addr_seen <= 1'b0;
            captured     <= 1'b0;
            tx_done      <= 1'b0;
            timed_out    <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (abort) begin
                // A timeout was already reported, so the closing deselect stays silent.
                frame_err <= incomplete && !timed_out;
                sr        <= '0;
                bit_cnt   <= '0;
                wait_cnt  <= '0;
                captured  <= 1'b0;
                tx_done   <= 1'b0;
                timed_out <= 1'b0;
            end else begin
                if (receiving && !rx_done) begin
                    sr      <= {sr[RX_W-3:0], MOSI};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == RX_LAST) begin
                        rx_data  <= {sr, MOSI};
                        rx_valid <= 1'b1;
                        if (cs == READ_ADD) rd_addr_seen <= 1'b1;
                    end
                end
                if (load) captured <= 1'b1;
                if (ser_done) begin
                    tx_done      <= 1'b1;
                    rd_addr_seen <= 1'b0;
                end
                if ((TX_WAIT_MAX > 0) && waiting && !tx_valid) begin
                    if (wait_cnt == WAIT_LAST) begin
                        frame_err <= 1'b1;
                        timed_out <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
            end
        end
    end

    spi_miso_serializer #(.DATA_W(DATA_W)) u_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .clear (abort),
        .data  (tx_data),
        .MISO  (MISO),
        .busy  (ser_busy),
        .done  (ser_done)
    );

endmodule

// File: tb/tb_spi_slave_param.sv
// Scoreboard bench for spi_slave_param (DATA_W=8, TX_WAIT_MAX=4): stimulus queues expected
// rx/frame_err events and MISO bits; a monitor compares them as the DUT presents outputs.
module tb_spi_slave_param;
    import shared_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    spi_state_e cs;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    typedef struct {
        int         at_edge;
        logic [9:0] data;
    } rx_exp_t;

    rx_exp_t rx_q[$];
    int      err_q[$];
    bit      exp_miso[int];

    spi_slave_param #(.DATA_W(8), .TX_WAIT_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .MISO      (MISO),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .cs        (cs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, edge_n);
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rx_valid) begin
                if (rx_q.size() == 0) begin
                    check("rx_valid_unexpected", 32'(rx_valid), 32'd0);
                end else begin
                    rx_exp_t e;
                    e = rx_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.data));
                    check("rx_valid_edge", 32'(edge_n), 32'(e.at_edge));
                end
            end
            if (frame_err) begin
                if (err_q.size() == 0) begin
                    check("frame_err_unexpected", 32'(frame_err), 32'd0);
                end else begin
                    int ee;
                    ee = err_q.pop_front();
                    check("frame_err_edge", 32'(edge_n), 32'(ee));
                end
            end
            check("miso", 32'(MISO), exp_miso.exists(edge_n) ? 32'(exp_miso[edge_n]) : 32'd0);
        end
    end

    // Drive at a falling edge, then wait one full cycle; the rising edge in between samples it.
    task automatic step(input logic ss, input logic mosi);
        SS_n = ss;
        MOSI = mosi;
        @(negedge clk);
    endtask

    task automatic frame(input logic pre, input logic [9:0] bits, input int nbits,
                         input bit push_rx, input spi_state_e exp_state);
        step(1'b0, 1'b0);
        check("cs_chk_cmd", 32'(cs), 32'(CHK_CMD));
        step(1'b0, pre);
        check("cs_after_cmd", 32'(cs), 32'(exp_state));
        for (int i = 0; i < nbits; i++) begin
            if (push_rx && i == 9) rx_q.push_back('{at_edge: edge_n + 1, data: bits});
            step(1'b0, bits[9-i]);
        end
    endtask

    task automatic expect_miso_word(input int first_edge, input logic [7:0] word);
        for (int i = 0; i < 8; i++) exp_miso[first_edge + i] = word[7-i];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cs", 32'(cs), 32'(IDLE));
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write frame.
        frame(1'b0, 10'b00_1010_0101, 10, 1'b1, WRITE);
        step(1'b1, 1'b0);
        check("cs_idle_after_write", 32'(cs), 32'(IDLE));

        // Read address, then read data 0x3C; a second tx_valid with 0xFF must be ignored.
        frame(1'b1, 10'b10_0000_0011, 10, 1'b1, READ_ADD);
        step(1'b1, 1'b0);
        frame(1'b1, 10'b11_0000_0000, 10, 1'b1, READ_DATA);
        e = edge_n;
        expect_miso_word(e + 1, 8'h3C);
        tx_data = 8'h3C; tx_valid = 1'b1;
        step(1'b0, 1'b0);
        tx_data = 8'hFF;
        step(1'b0, 1'b0);
        tx_valid = 1'b0;
        repeat (9) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("cs_idle_after_read", 32'(cs), 32'(IDLE));

        // Completed read cleared rd_addr_seen: next read goes to READ_ADD.
        frame(1'b1, 10'b10_0000_0001, 10, 1'b1, READ_ADD);
        step(1'b1, 1'b0);

        // Abort after 6 bits.
        frame(1'b0, 10'b01_1111_0000, 6, 1'b0, WRITE);
        err_q.push_back(edge_n + 1);
        step(1'b1, 1'b0);
        check("cs_idle_after_abort", 32'(cs), 32'(IDLE));

        // Abort on the last bit: no rx_valid, rx_data keeps 0x201.
        frame(1'b0, 10'b01_0101_0101, 9, 1'b0, WRITE);
        err_q.push_back(edge_n + 1);
        step(1'b1, 1'b1);
        check("cs_idle_after_last_abort", 32'(cs), 32'(IDLE));
        check("rx_data_hold", 32'(rx_data), 32'h201);
        step(1'b1, 1'b0);

        // Timeout: rd_addr_seen is set, tx_valid never comes.
        frame(1'b1, 10'b11_0000_0000, 10, 1'b1, READ_DATA);
        e = edge_n;
        err_q.push_back(e + 4);
        repeat (8) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("cs_idle_after_timeout", 32'(cs), 32'(IDLE));

        // Retry goes straight to READ_DATA and serialises 0xA5.
        frame(1'b1, 10'b11_1111_1111, 10, 1'b1, READ_DATA);
        e = edge_n;
        expect_miso_word(e + 1, 8'hA5);
        tx_data = 8'hA5; tx_valid = 1'b1;
        step(1'b0, 1'b0);
        tx_valid = 1'b0;
        repeat (9) step(1'b0, 1'b0);
        step(1'b1, 1'b0);

        // Asynchronous reset in the middle of a write frame.
        frame(1'b0, 10'b00_1111_1111, 5, 1'b0, WRITE);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cs", 32'(cs), 32'(IDLE));
        check("midrst_miso", 32'(MISO), 32'd0);
        check("midrst_rx_valid", 32'(rx_valid), 32'd0);
        check("midrst_rx_data", 32'(rx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b1, 1'b0);

        check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
        check("err_queue_drained", 32'(err_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
